instr_loader: RTL and testbench

Instruction-side responder for the single-cycle core. Holds a program image in an internal word RAM, loads it from a host byte stream while holding the core in reset, then serves `instr` for every `pc_address` the core presents. Sits between the host/debug link and the core's `instr`/`pc_address`/`rst` pins.

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader_word_packer.sv | 44 ++++
 rtl/instr_loader.sv | 149 ++++++++++++++
 tb/tb_instr_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    RUN  = 3'd4
  } state_e;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam int unsigned HDR_BYTES = 32'd2;

endpackage

// File: rtl/instr_loader_if.sv
// Host byte stream plus core fetch port of the instruction loader.
interface instr_loader_if;
  import instr_loader_pkg::*;

  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        core_rst;
  logic [31:0] pc_address;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        overflow;

  modport master (
    output load_start, byte_valid, byte_data, pc_address,
    input  byte_ready, core_rst, instr, fetch_fault, overflow
  );

  modport slave (
    input  load_start, byte_valid, byte_data, pc_address,
    output byte_ready, core_rst, instr, fetch_fault, overflow
  );

endinterface

// File: rtl/instr_loader_word_packer.sv
// Assembles four little-endian bytes into a 32-bit word; word_valid pulses
// with the byte that completes lane 3.
module word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane_r;
  logic [23:0] hold_r;

  // Lane counter and hold register for the three lower bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r <= 2'd0;
      hold_r <= 24'd0;
    end else if (clear) begin
      lane_r <= 2'd0;
      hold_r <= 24'd0;
    end else if (byte_en) begin
      lane_r <= lane_r + 2'd1;
      case (lane_r)
        2'd0:    hold_r[7:0]   <= byte_data;
        2'd1:    hold_r[15:8]  <= byte_data;
        2'd2:    hold_r[23:16] <= byte_data;
        default: hold_r        <= hold_r;
      endcase
    end else begin
      lane_r <= lane_r;
      hold_r <= hold_r;
    end
  end

  // The top byte is taken straight from the input so the word is ready on the lane-3 edge.
  assign word_valid = byte_en && (lane_r == 2'd3);
  assign word_data  = {byte_data, hold_r};

endmodule

// File: rtl/instr_loader.sv
// Loads a program image from a host byte stream into a word RAM while the
// core is held in reset, then serves instruction fetches from it.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256
)
(
  input  logic           clk,
  input  logic           rst,
  instr_loader_if.slave  bus
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W    = 17'(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

  state_e      state_r;
  state_e      state_s;
  logic [15:0] count_r;
  logic [15:0] index_r;
  logic        core_rst_r;
  logic        overflow_r;
  logic [31:0] mem_r [DEPTH];

  logic        byte_ready_s;
  logic        byte_fire_s;
  logic        start_s;
  logic        pack_clear_s;
  logic        pack_en_s;
  logic        word_valid_s;
  logic [31:0] word_data_s;
  logic        index_in_range_s;
  logic        last_word_s;
  logic [31:0] instr_s;
  logic        fetch_fault_s;

  assign byte_ready_s     = (state_r == HDR0) || (state_r == HDR1) || (state_r == DATA);
  assign byte_fire_s      = bus.byte_valid && byte_ready_s;
  assign start_s          = bus.load_start && ((state_r == IDLE) || (state_r == RUN));
  assign pack_clear_s     = byte_fire_s && (state_r == HDR1);
  assign pack_en_s        = byte_fire_s && (state_r == DATA);
  assign index_in_range_s = ({1'b0, index_r} < DEPTH_W);
  assign last_word_s      = word_valid_s && (index_r == (count_r - 16'd1));

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_s),
    .byte_en    (pack_en_s),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid_s),
    .word_data  (word_data_s)
  );

  // Load sequencer next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load_start) state_s = HDR0;
        else                state_s = IDLE;
      end
      HDR0: begin
        if (byte_fire_s) state_s = HDR1;
        else             state_s = HDR0;
      end
      HDR1: begin
        if (byte_fire_s) begin
          if ({bus.byte_data, count_r[7:0]} == 16'd0) state_s = RUN;
          else                                        state_s = DATA;
        end else begin
          state_s = HDR1;
        end
      end
      DATA: begin
        if (last_word_s) state_s = RUN;
        else             state_s = DATA;
      end
      RUN: begin
        if (bus.load_start) state_s = HDR0;
        else                state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, header count, word index, core reset and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      count_r    <= 16'd0;
      index_r    <= 16'd0;
      core_rst_r <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      core_rst_r <= (state_s != RUN);
      if (start_s) begin
        overflow_r <= 1'b0;
      end else if (word_valid_s && !index_in_range_s) begin
        overflow_r <= 1'b1;
      end
      if (byte_fire_s && (state_r == HDR0)) begin
        count_r[7:0] <= bus.byte_data;
      end
      if (byte_fire_s && (state_r == HDR1)) begin
        count_r[15:8] <= bus.byte_data;
      end
      if (pack_clear_s) begin
        index_r <= 16'd0;
      end else if (word_valid_s) begin
        index_r <= index_r + 16'd1;
      end
    end
  end

  // Program RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (word_valid_s && index_in_range_s) begin
      mem_r[index_r[AW-1:0]] <= word_data_s;
    end
  end

  // Combinational fetch: only RUN serves RAM, and only for aligned in-range addresses.
  always_comb begin
    instr_s       = NOP_WORD;
    fetch_fault_s = 1'b0;
    if (state_r == RUN) begin
      if ((bus.pc_address[1:0] != 2'd0) || ({1'b0, bus.pc_address} >= ADDR_LIMIT)) begin
        instr_s       = NOP_WORD;
        fetch_fault_s = 1'b1;
      end else begin
        instr_s       = mem_r[bus.pc_address[AW+1:2]];
        fetch_fault_s = 1'b0;
      end
    end else begin
      instr_s       = NOP_WORD;
      fetch_fault_s = 1'b0;
    end
  end

  assign bus.byte_ready  = byte_ready_s;
  assign bus.core_rst    = core_rst_r;
  assign bus.overflow    = overflow_r;
  assign bus.instr       = instr_s;
  assign bus.fetch_fault = fetch_fault_s;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a 256-word and a 4-word instance share
// the same stimulus and are compared against an array-based image model.
module tb_instr_loader;

  localparam int unsigned BIG   = 256;
  localparam int unsigned SMALL = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;

  instr_loader_if bus_big ();
  instr_loader_if bus_small ();

  instr_loader #(.DEPTH(BIG))   u_big   (.clk(clk), .rst(rst), .bus(bus_big));
  instr_loader #(.DEPTH(SMALL)) u_small (.clk(clk), .rst(rst), .bus(bus_small));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_big   [BIG];
  bit          wr_big  [BIG];
  logic [31:0] m_small [SMALL];
  bit          wr_small[SMALL];
  bit          running;
  bit          exp_ovf_big;
  bit          exp_ovf_small;
  logic [31:0] wq [$];
  logic [31:0] saved [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input int unsigned depth, input logic [31:0] pc);
    return (pc[1:0] == 2'd0) && ({32'd0, pc} < 64'(4 * depth));
  endfunction

  task automatic set_inputs(input logic ls, input logic v, input logic [7:0] d);
    bus_big.load_start   = ls;
    bus_small.load_start = ls;
    bus_big.byte_valid   = v;
    bus_small.byte_valid = v;
    bus_big.byte_data    = d;
    bus_small.byte_data  = d;
  endtask

  task automatic check_fetch(input logic [31:0] pc);
    @(negedge clk);
    bus_big.pc_address   = pc;
    bus_small.pc_address = pc;
    #1;
    if (!running) begin
      check_val("instr_idle_big", bus_big.instr, NOP);
      check_val("fault_idle_big", bus_big.fetch_fault, 32'd0);
      check_val("instr_idle_small", bus_small.instr, NOP);
      check_val("fault_idle_small", bus_small.fetch_fault, 32'd0);
    end else begin
      if (addr_ok(BIG, pc)) begin
        check_val("fault_big", bus_big.fetch_fault, 32'd0);
        if (wr_big[pc[9:2]]) check_val("instr_big", bus_big.instr, m_big[pc[9:2]]);
      end else begin
        check_val("fault_big", bus_big.fetch_fault, 32'd1);
        check_val("instr_fault_big", bus_big.instr, NOP);
      end
      if (addr_ok(SMALL, pc)) begin
        check_val("fault_small", bus_small.fetch_fault, 32'd0);
        if (wr_small[pc[3:2]]) check_val("instr_small", bus_small.instr, m_small[pc[3:2]]);
      end else begin
        check_val("fault_small", bus_small.fetch_fault, 32'd1);
        check_val("instr_fault_small", bus_small.instr, NOP);
      end
    end
  endtask

  task automatic random_fetches(input int k);
    logic [31:0] pc;
    for (int i = 0; i < k; i++) begin
      case ($urandom_range(0, 3))
        0:       pc = 32'(4 * $urandom_range(0, 11));
        1:       pc = 32'(4 * $urandom_range(0, 11) + $urandom_range(1, 3));
        2:       pc = $urandom;
        default: pc = 32'(4 * $urandom_range(250, 260));
      endcase
      check_fetch(pc);
    end
  endtask

  // Pulse load_start, optionally with a coincident byte that must not be taken.
  task automatic start_load(input bit with_byte);
    @(negedge clk);
    set_inputs(1'b1, with_byte, 8'($urandom));
    #1;
    if (running) begin
      check_val("ready_run_big", bus_big.byte_ready, 32'd0);
      check_val("ready_run_small", bus_small.byte_ready, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 8'd0);
    running       = 1'b0;
    exp_ovf_big   = 1'b0;
    exp_ovf_small = 1'b0;
    #1;
    check_val("core_rst_load_big", bus_big.core_rst, 32'd1);
    check_val("core_rst_load_small", bus_small.core_rst, 32'd1);
    check_val("ready_hdr_big", bus_big.byte_ready, 32'd1);
    check_val("ovf_clear_big", bus_big.overflow, 32'd0);
    check_val("ovf_clear_small", bus_small.overflow, 32'd0);
  endtask

  // Stream the header and the words of wq; gap_mode 0 = dense, 1 = alternate, 2 = random.
  task automatic send_stream(input int gap_mode, input int abort_after, input bit ls_in_data);
    logic [7:0]  bq [$];
    logic [31:0] wv;
    int n, sent, cyc, budget, done_words, nb;
    bit v;
    n    = wq.size();
    sent = 0;
    cyc  = 0;
    for (int h = 0; h < int'(instr_loader_pkg::HDR_BYTES); h++) bq.push_back(8'((n >> (8 * h)) & 255));
    for (int i = 0; i < n; i++) begin
      wv = wq[i];
      for (int b = 0; b < 4; b++) bq.push_back(wv[8*b +: 8]);
    end
    nb     = bq.size();
    budget = 4 * nb + 16;
    while (sent < nb && cyc < budget && !(abort_after >= 0 && sent >= abort_after)) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      set_inputs(ls_in_data && (sent == 3), v, v ? bq[sent] : 8'($urandom));
      #1;
      check_val("ready_load_big", bus_big.byte_ready, 32'd1);
      check_val("ready_load_small", bus_small.byte_ready, 32'd1);
      if (v && sent == nb - 1) begin
        check_val("core_rst_pre_big", bus_big.core_rst, 32'd1);
        check_val("core_rst_pre_small", bus_small.core_rst, 32'd1);
      end
      @(posedge clk);
      if (v) sent++;
      cyc++;
      @(negedge clk);
    end
    set_inputs(1'b0, 1'b0, 8'd0);
    done_words = (abort_after >= 0) ? ((sent > 2) ? (sent - 2) / 4 : 0) : n;
    for (int i = 0; i < done_words; i++) begin
      if (i < int'(BIG))   begin m_big[i]   = wq[i]; wr_big[i]   = 1'b1; end
      if (i < int'(SMALL)) begin m_small[i] = wq[i]; wr_small[i] = 1'b1; end
    end
    if (abort_after < 0) begin
      check_val("stream_bytes", 32'(sent), 32'(nb));
      running       = 1'b1;
      exp_ovf_big   = (n > int'(BIG));
      exp_ovf_small = (n > int'(SMALL));
      #1;
      check_val("core_rst_run_big", bus_big.core_rst, 32'd0);
      check_val("core_rst_run_small", bus_small.core_rst, 32'd0);
      check_val("ready_run_big", bus_big.byte_ready, 32'd0);
      check_val("ovf_big", bus_big.overflow, 32'(exp_ovf_big));
      check_val("ovf_small", bus_small.overflow, 32'(exp_ovf_small));
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    running       = 1'b0;
    exp_ovf_big   = 1'b0;
    exp_ovf_small = 1'b0;
    check_val("core_rst_abort_big", bus_big.core_rst, 32'd1);
    check_val("core_rst_abort_small", bus_small.core_rst, 32'd1);
    check_val("ready_abort_big", bus_big.byte_ready, 32'd0);
    check_val("ovf_abort_small", bus_small.overflow, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    running = 1'b0;
    exp_ovf_big = 1'b0;
    exp_ovf_small = 1'b0;
    set_inputs(1'b0, 1'b0, 8'd0);
    bus_big.pc_address   = 32'd0;
    bus_small.pc_address = 32'd0;
    repeat (2) @(negedge clk);
    check_val("rst_core_rst", bus_big.core_rst, 32'd1);
    check_val("rst_ready", bus_big.byte_ready, 32'd0);
    check_val("rst_instr", bus_big.instr, NOP);
    check_val("rst_fault", bus_big.fetch_fault, 32'd0);
    check_val("rst_ovf", bus_small.overflow, 32'd0);
    rst = 1'b0;
    check_fetch(32'd0);
    check_fetch(32'd2);

    // Reference program of two words
    wq.delete();
    wq.push_back(32'h0050_0093);
    wq.push_back(32'h00A0_0113);
    start_load(1'b0);
    send_stream(0, -1, 1'b0);
    check_fetch(32'd4);
    check_fetch(32'd0);
    check_fetch(32'd2);
    check_fetch(32'd1024);
    check_fetch(32'd16);

    // Five words overflow the small instance; load_start in DATA is ignored
    fill_random(5);
    saved = wq;
    start_load(1'b1);
    send_stream(2, -1, 1'b1);
    random_fetches(8);

    // Scramble the image, then reload the saved words with alternate-cycle valid
    fill_random(5);
    start_load(1'b0);
    send_stream(0, -1, 1'b0);
    wq = saved;
    start_load(1'b0);
    send_stream(1, -1, 1'b0);
    for (int i = 0; i < 5; i++) check_fetch(32'(4 * i));

    // Empty image: RUN right after the header, stale words still served
    wq.delete();
    start_load(1'b0);
    send_stream(0, -1, 1'b0);
    random_fetches(4);

    // Reset after five data bytes, then a fresh load
    fill_random(3);
    start_load(1'b0);
    send_stream(0, 7, 1'b0);
    do_reset();
    check_fetch(32'd0);
    fill_random(3);
    start_load(1'b0);
    send_stream(1, -1, 1'b0);
    random_fetches(6);

    for (int it = 0; it < 6; it++) begin
      fill_random($urandom_range(0, 10));
      start_load($urandom_range(0, 1) == 1);
      send_stream($urandom_range(0, 2), -1, $urandom_range(0, 1) == 1);
      random_fetches(6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
